// File: rtl/tristate_pin_arbiter_if.sv
// rtl/tristate_pin_arbiter_if.sv - requester and pin-drive bundle for the tristate pin arbiter
interface tristate_pin_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] value;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             pin_enable;
  logic             pin_value;

  modport master (
    output req,
    output value,
    input  grant,
    input  busy,
    input  pin_enable,
    input  pin_value
  );

  modport slave (
    input  req,
    input  value,
    output grant,
    output busy,
    output pin_enable,
    output pin_value
  );
endinterface

// File: rtl/tristate_pin_arbiter.sv
// rtl/tristate_pin_arbiter.sv - round-robin owner arbitration for one shared tristate pin
module tristate_pin_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 2,
  parameter int MAX_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tristate_pin_arbiter_if.slave bus
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LOAD  = TW'(TURNAROUND);
  localparam logic [OW-1:0] LAST_IDX   = OW'(N_REQ - 1);
  localparam logic [OW:0]   N_WIDE     = (OW + 1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } state_t;

  state_t           state;
  logic [OW-1:0]    ptr;
  logic [OW-1:0]    owner;
  logic [HW-1:0]    hold;
  logic [TW-1:0]    turn;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;
  logic             en_q;
  logic             val_q;

  logic             pick_valid;
  logic [OW-1:0]    pick;
  logic [OW:0]      sum;
  logic             release_now;

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    sum        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (OW + 1)'(k);
      if (sum >= N_WIDE) begin
        sum = sum - N_WIDE;
      end
      if (bus.req[sum[OW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = sum[OW-1:0];
      end
    end
  end

  always_comb begin
    release_now = !bus.req[owner];
    if ((MAX_HOLD != 0) && (hold == HOLD_LIMIT)) begin
      release_now = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      hold    <= '0;
      turn    <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= DRIVE;
            owner   <= pick;
            grant_q <= {{(N_REQ - 1){1'b0}}, 1'b1} << pick;
            en_q    <= 1'b1;
            val_q   <= bus.value[pick];
            hold    <= HW'(1);
            busy_q  <= 1'b1;
          end
        end
        DRIVE: begin
          if (release_now) begin
            state   <= TURN;
            grant_q <= '0;
            en_q    <= 1'b0;
            val_q   <= 1'b0;
            ptr     <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
            turn    <= TURN_LOAD;
          end else begin
            val_q <= bus.value[owner];
            // Saturates only matters for unlimited holds; a limited hold releases first.
            if (hold != {HW{1'b1}}) begin
              hold <= hold + 1'b1;
            end
          end
        end
        TURN: begin
          turn <= turn - 1'b1;
          if (turn == TW'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          en_q    <= 1'b0;
          val_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.pin_enable = en_q;
  assign bus.pin_value  = val_q;

endmodule
